voq_manager: RTL and testbench
==============================

// Module: voq_manager
// PURPOSE
//  Per-egress virtual output queues holding frame-buffer pointers between the ingress write path and tx_mac_control.
//  Accepts one (pointer, destination mask) per cycle. Presents the head pointer of each port queue on voq_valid_o/voq_ptr_o.
//  Keeps a per-buffer reference count so multicast/broadcast frames are freed once, after the last egress port dequeues them.
// PARAMETERS
//  NUM_PORTS    4   egress ports / queues
//  VOQ_DEPTH    16  frame-buffer slots; PTR_W = $clog2(VOQ_DEPTH)
//  QUEUE_DEPTH  8   entries per port queue (power of 2); CNT_W = $clog2(QUEUE_DEPTH)+1
// PORTS
//  switch_clk     in   1                      switch core clock
//  switch_rst     in   1                      asynchronous, active-high reset
//  enq_valid_i    in   1                      enqueue request
//  enq_ptr_i      in   PTR_W                  buffer slot holding the frame
//  enq_dst_mask_i in   NUM_PORTS              destination ports (bit p = port p)
//  enq_ready_o    out  1                      enqueue accepted when valid&&ready
//  voq_valid_o    out  1 [NUM_PORTS]          port queue non-empty
//  voq_ptr_o      out  PTR_W [NUM_PORTS]      head pointer of port queue
//  voq_ready_i    in   1 [NUM_PORTS]          tx_mac_control idle; pop when valid&&ready
//  free_valid_o   out  1                      buffer slot released this cycle
//  free_ptr_o     out  PTR_W                  released slot
//  occupancy_o    out  CNT_W [NUM_PORTS]      current entries per queue
// BEHAVIOUR
//  Reset (async assert, sync deassert outside): all queues empty, rd/wr ptrs 0, refcounts 0, pending-free bitmap 0.
//   Outputs: voq_valid_o=0, voq_ptr_o=0, free_valid_o=0, free_ptr_o=0, occupancy_o=0, enq_ready_o=1.
//  Reset mid-operation discards all queued pointers; no free pulses are issued for them.
//  enq_ready_o: combinational. 1 iff no port p with enq_dst_mask_i[p]=1 has occupancy==QUEUE_DEPTH.
//   Uses the current count, so a same-cycle pop does not make room. Independent of enq_valid_i.
//  Enqueue at edge N: enq_ptr_i is written to every masked queue and refcount[ptr] <= popcount(mask).
//   voq_valid_o rises in cycle N+1. There is no same-cycle bypass.
//  Mask == 0: the frame is dropped. Pending[ptr] is set, so the free pulse occurs as if the refcount had hit zero.
//  Dequeue: voq_ptr_o[p] = mem[p][rd_ptr] (registered storage, combinational read). The pop advances rd_ptr at the edge.
//  Same port, same cycle push + pop: both happen, occupancy unchanged. Pop from an empty queue is ignored.
//  Pointers wrap modulo QUEUE_DEPTH. Full/empty come from CNT_W-bit occupancy, not pointer compare.
//  Refcount: each edge, refcount[x] -= number of ports popping pointer x this cycle (0..NUM_PORTS, summed).
//   When it reaches 0, pending[x] <= 1.
//  Free output: free_valid_o = |pending; free_ptr_o = lowest set index. That bit clears at the edge.
//   One free per cycle; the allocator never back-pressures.
//   Earliest free: cycle after the final pop. Simultaneous zeros are queued in the bitmap, lowest first.
//  Pending bit set and cleared same edge for different slots: both apply. The same slot cannot be both (refcount>0 until set).
//  Protocol violations, flagged by assertions in simulation: enqueue of a ptr with refcount!=0 or pending=1; enqueue while !enq_ready_o.
// CONFIGURATION
//  VOQ_STATS_EN defined: adds per-port outputs stat_enq_cnt_o [NUM_PORTS] 32b and stat_hwm_o [NUM_PORTS] CNT_W.
//   stat_enq_cnt_o: accepted enqueues, wraps at 2^32.
//   stat_hwm_o: max occupancy seen, updated on the cycle after the change.
//   Both reset to 0.
//  VOQ_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  Unicast: enq ptr=5 mask=0010, voq_ready_i[1]=0 -> voq_valid_o[1]=1 at N+1, voq_ptr_o[1]=5; ready=1 1 cycle -> free_ptr_o=5 next cycle.
//  Broadcast: enq ptr=3 mask=1111; pop ports 0,2 same cycle, ports 1,3 later -> exactly one free of 3, cycle after last pop.
//  Full: 8 enqs to port 0 with ready=0 -> enq_ready_o=0 for mask 0001, still 1 for mask 0100; one pop restores ready next cycle.
//  Push+pop same cycle at occupancy 4 -> occupancy stays 4; order FIFO (ptrs 1,2,3,4,9 pop in that order).
//  Mask 0 with ptr=7 -> no voq_valid_o; free_ptr_o=7 next cycle; two slots 2 and 6 hitting zero together -> frees 2 then 6.
//  Reset asserted with 3 queued -> all voq_valid_o=0, no free pulse; with VOQ_STATS_EN, stat_hwm_o=0 after reset.

Source files
------------

// File: rtl/voq_manager.sv
// voq_manager: per-egress virtual output queues of frame-buffer pointers with
// per-slot reference counting so multicast frames are released exactly once.
// Optional per-port statistics (accepted enqueues, occupancy high-water mark)
// are built when the VOQ_STATS_EN macro is defined.

module voq_manager #(
  parameter int NUM_PORTS   = 4,
  parameter int VOQ_DEPTH   = 16,
  parameter int QUEUE_DEPTH = 8,
  localparam int PTR_W      = $clog2(VOQ_DEPTH),
  localparam int CNT_W      = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                 switch_clk,
  input  logic                 switch_rst,
  input  logic                 enq_valid_i,
  input  logic [PTR_W-1:0]     enq_ptr_i,
  input  logic [NUM_PORTS-1:0] enq_dst_mask_i,
  output logic                 enq_ready_o,
  output logic [NUM_PORTS-1:0] voq_valid_o,
  output logic [PTR_W-1:0]     voq_ptr_o [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] voq_ready_i,
  output logic                 free_valid_o,
  output logic [PTR_W-1:0]     free_ptr_o,
`ifdef VOQ_STATS_EN
  output logic [31:0]          stat_enq_cnt_o [NUM_PORTS],
  output logic [CNT_W-1:0]     stat_hwm_o [NUM_PORTS],
`endif
  output logic [CNT_W-1:0]     occupancy_o [NUM_PORTS]
);

  localparam int AW   = $clog2(QUEUE_DEPTH);
  localparam int RC_W = $clog2(NUM_PORTS + 1);

  logic [PTR_W-1:0]     mem_q [NUM_PORTS][QUEUE_DEPTH];
  logic [PTR_W-1:0]     mem_d [NUM_PORTS][QUEUE_DEPTH];
  logic [AW-1:0]        rd_q [NUM_PORTS], rd_d [NUM_PORTS];
  logic [AW-1:0]        wr_q [NUM_PORTS], wr_d [NUM_PORTS];
  logic [CNT_W-1:0]     occ_q [NUM_PORTS], occ_d [NUM_PORTS];
  logic [RC_W-1:0]      ref_q [VOQ_DEPTH], ref_d [VOQ_DEPTH];
  logic [VOQ_DEPTH-1:0] pend_q, pend_d;

  logic [NUM_PORTS-1:0] push_s, pop_s;
  logic [PTR_W-1:0]     head_s [NUM_PORTS];
  logic                 enq_ready_s, enq_acc_s;
  logic [RC_W-1:0]      pop_cnt_s;
  logic                 free_valid_s;
  logic [PTR_W-1:0]     free_idx_s;
  logic [VOQ_DEPTH-1:0] slot_busy_s;

  // Admission, per-port push/pop qualification and head-of-queue read.
  always_comb begin
    enq_ready_s = 1'b1;
    pop_cnt_s   = {RC_W{1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      // Full test uses the registered count: a same-cycle pop does not make room.
      enq_ready_s = enq_ready_s & ~(enq_dst_mask_i[p] & (occ_q[p] == CNT_W'(QUEUE_DEPTH)));
      pop_cnt_s   = pop_cnt_s + RC_W'(enq_dst_mask_i[p]);
      head_s[p]   = mem_q[p][rd_q[p]];
      pop_s[p]    = voq_ready_i[p] & (occ_q[p] != {CNT_W{1'b0}});
    end
    enq_acc_s = enq_valid_i & enq_ready_s;
    push_s    = enq_dst_mask_i & {NUM_PORTS{enq_acc_s}};
  end

  // Queue storage, read/write pointers and occupancy next state.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push_s[p]) begin
        mem_d[p][wr_q[p]] = enq_ptr_i;
        wr_d[p]           = wr_q[p] + AW'(1);
      end else begin
        wr_d[p]           = wr_q[p];
      end
      rd_d[p]  = rd_q[p] + AW'(pop_s[p]);
      occ_d[p] = occ_q[p] + CNT_W'(push_s[p]) - CNT_W'(pop_s[p]);
    end
  end

  // Reference counts and the pending-free bitmap (lowest index freed first).
  always_comb begin
    logic [RC_W-1:0]      dec;
    logic [VOQ_DEPTH-1:0] set_v;
    logic [VOQ_DEPTH-1:0] clr_v;
    free_idx_s = {PTR_W{1'b0}};
    for (int i = VOQ_DEPTH - 1; i >= 0; i--) begin
      free_idx_s = pend_q[i] ? PTR_W'(i) : free_idx_s;
    end
    free_valid_s = |pend_q;
    clr_v = free_valid_s ? ({{(VOQ_DEPTH-1){1'b0}}, 1'b1} << free_idx_s) : {VOQ_DEPTH{1'b0}};
    set_v = {VOQ_DEPTH{1'b0}};
    for (int x = 0; x < VOQ_DEPTH; x++) begin
      dec = {RC_W{1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
        dec = dec + RC_W'(pop_s[p] && (head_s[p] == PTR_W'(x)));
      end
      ref_d[x]       = ref_q[x] - dec;
      set_v[x]       = (ref_q[x] != {RC_W{1'b0}}) && (ref_q[x] == dec);
      slot_busy_s[x] = (ref_q[x] != {RC_W{1'b0}});
    end
    if (enq_acc_s) begin
      ref_d[enq_ptr_i] = pop_cnt_s;
      // A frame with no destination is released as if its count had expired.
      set_v[enq_ptr_i] = set_v[enq_ptr_i] | (enq_dst_mask_i == {NUM_PORTS{1'b0}});
    end else begin
      set_v = set_v;
    end
    pend_d = (pend_q & ~clr_v) | set_v;
  end

  // State registers; reset discards all queued pointers without free pulses.
  always_ff @(posedge switch_clk or posedge switch_rst) begin
    if (switch_rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[p][i] <= {PTR_W{1'b0}};
        rd_q[p]  <= {AW{1'b0}};
        wr_q[p]  <= {AW{1'b0}};
        occ_q[p] <= {CNT_W{1'b0}};
      end
      for (int x = 0; x < VOQ_DEPTH; x++) ref_q[x] <= {RC_W{1'b0}};
      pend_q <= {VOQ_DEPTH{1'b0}};
    end else begin
      mem_q  <= mem_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      occ_q  <= occ_d;
      ref_q  <= ref_d;
      pend_q <= pend_d;
    end
  end

  assign enq_ready_o  = enq_ready_s;
  assign free_valid_o = free_valid_s;
  assign free_ptr_o   = free_idx_s;
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      voq_valid_o[p] = (occ_q[p] != {CNT_W{1'b0}});
      voq_ptr_o[p]   = head_s[p];
      occupancy_o[p] = occ_q[p];
    end
  end

`ifdef VOQ_STATS_EN
  logic [31:0]      enq_cnt_q [NUM_PORTS], enq_cnt_d [NUM_PORTS];
  logic [CNT_W-1:0] hwm_q [NUM_PORTS], hwm_d [NUM_PORTS];

  // Statistics next state: the high-water mark follows the registered occupancy.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      enq_cnt_d[p] = enq_cnt_q[p] + {31'd0, push_s[p]};
      hwm_d[p]     = (occ_q[p] > hwm_q[p]) ? occ_q[p] : hwm_q[p];
    end
  end

  // Statistics registers.
  always_ff @(posedge switch_clk or posedge switch_rst) begin
    if (switch_rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        enq_cnt_q[p] <= 32'd0;
        hwm_q[p]     <= {CNT_W{1'b0}};
      end
    end else begin
      enq_cnt_q <= enq_cnt_d;
      hwm_q     <= hwm_d;
    end
  end

  assign stat_enq_cnt_o = enq_cnt_q;
  assign stat_hwm_o     = hwm_q;
`endif

  voq_manager_chk #(.VOQ_DEPTH(VOQ_DEPTH), .PTR_W(PTR_W)) u_chk (
    .clk       (switch_clk),
    .rst       (switch_rst),
    .enq_valid (enq_valid_i),
    .enq_ready (enq_ready_s),
    .enq_ptr   (enq_ptr_i),
    .slot_busy (slot_busy_s),
    .slot_pend (pend_q)
  );

endmodule

// Protocol checks on the enqueue interface.
module voq_manager_chk #(
  parameter int VOQ_DEPTH = 16,
  parameter int PTR_W     = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 enq_valid,
  input logic                 enq_ready,
  input logic [PTR_W-1:0]     enq_ptr,
  input logic [VOQ_DEPTH-1:0] slot_busy,
  input logic [VOQ_DEPTH-1:0] slot_pend
);
  a_enq_when_ready: assert property (@(posedge clk) disable iff (rst)
    enq_valid |-> enq_ready);
  a_enq_slot_idle: assert property (@(posedge clk) disable iff (rst)
    (enq_valid && enq_ready) |-> (!slot_busy[enq_ptr] && !slot_pend[enq_ptr]));
endmodule

// File: tb/tb_voq_manager.sv
// Self-checking bench for voq_manager: directed table, corner sequences and
// randomized traffic against a queue-level reference model.

module tb_voq_manager;
  localparam int NP = 4;
  localparam int VD = 16;
  localparam int QD = 8;
  localparam int PW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_valid_i;
  logic [PW-1:0] enq_ptr_i;
  logic [NP-1:0] enq_dst_mask_i;
  logic          enq_ready_o;
  logic [NP-1:0] voq_valid_o;
  logic [PW-1:0] voq_ptr_o [NP];
  logic [NP-1:0] voq_ready_i;
  logic          free_valid_o;
  logic [PW-1:0] free_ptr_o;
  logic [CW-1:0] occupancy_o [NP];
`ifdef VOQ_STATS_EN
  logic [31:0]   stat_enq_cnt_o [NP];
  logic [CW-1:0] stat_hwm_o [NP];
`endif

  always #5 clk = ~clk;

  voq_manager dut (
    .switch_clk     (clk),
    .switch_rst     (rst),
    .enq_valid_i    (enq_valid_i),
    .enq_ptr_i      (enq_ptr_i),
    .enq_dst_mask_i (enq_dst_mask_i),
    .enq_ready_o    (enq_ready_o),
    .voq_valid_o    (voq_valid_o),
    .voq_ptr_o      (voq_ptr_o),
    .voq_ready_i    (voq_ready_i),
    .free_valid_o   (free_valid_o),
    .free_ptr_o     (free_ptr_o),
`ifdef VOQ_STATS_EN
    .stat_enq_cnt_o (stat_enq_cnt_o),
    .stat_hwm_o     (stat_hwm_o),
`endif
    .occupancy_o    (occupancy_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain FIFOs of pointers, reference counts and a free set.
  int mq [NP][$];
  int rc [VD];
  bit pend [VD];
  int m_enq [NP];
  int m_hwm [NP];

  typedef struct {
    logic          ev;
    logic [PW-1:0] ptr;
    logic [NP-1:0] mask;
    logic [NP-1:0] rdy;
    logic          exp_rdy;
    logic [NP-1:0] exp_vv;
    logic [PW-1:0] exp_p1;
    logic          exp_fv;
    logic [PW-1:0] exp_fp;
  } vec_t;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic bit m_ready(logic [NP-1:0] mask);
    for (int p = 0; p < NP; p++) if (mask[p] && mq[p].size() >= QD) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_clear();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      m_enq[p] = 0;
      m_hwm[p] = 0;
    end
    for (int x = 0; x < VD; x++) begin
      rc[x] = 0;
      pend[x] = 1'b0;
    end
  endfunction

  task automatic drive(logic ev, logic [PW-1:0] ptr, logic [NP-1:0] mask, logic [NP-1:0] rdy);
    enq_valid_i = ev;
    enq_ptr_i = ptr;
    enq_dst_mask_i = mask;
    voq_ready_i = rdy;
  endtask

  task automatic check_outputs();
    int lo;
    chk("enq_ready", enq_ready_o, m_ready(enq_dst_mask_i));
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("voq_valid[%0d]", p), voq_valid_o[p], mq[p].size() > 0);
      chk($sformatf("occupancy[%0d]", p), occupancy_o[p], mq[p].size());
      if (mq[p].size() > 0) chk($sformatf("voq_ptr[%0d]", p), voq_ptr_o[p], mq[p][0]);
`ifdef VOQ_STATS_EN
      chk($sformatf("stat_enq_cnt[%0d]", p), stat_enq_cnt_o[p], m_enq[p]);
      chk($sformatf("stat_hwm[%0d]", p), stat_hwm_o[p], m_hwm[p]);
`endif
    end
    lo = -1;
    for (int x = VD - 1; x >= 0; x--) if (pend[x]) lo = x;
    chk("free_valid", free_valid_o, lo >= 0);
    if (lo >= 0) chk("free_ptr", free_ptr_o, lo);
  endtask

  // Apply the effect of one clock edge to the model (inputs still stable).
  task automatic model_edge();
    bit acc;
    int cnt;
    int x;
    acc = enq_valid_i && m_ready(enq_dst_mask_i);
    for (int p = 0; p < NP; p++) if (mq[p].size() > m_hwm[p]) m_hwm[p] = mq[p].size();
    for (int i = 0; i < VD; i++) if (pend[i]) begin pend[i] = 1'b0; break; end
    for (int p = 0; p < NP; p++) begin
      if (voq_ready_i[p] && mq[p].size() > 0) begin
        x = mq[p].pop_front();
        rc[x]--;
        if (rc[x] == 0) pend[x] = 1'b1;
      end
    end
    if (acc) begin
      cnt = 0;
      for (int p = 0; p < NP; p++) if (enq_dst_mask_i[p]) begin
        mq[p].push_back(int'(enq_ptr_i));
        cnt++;
        m_enq[p]++;
      end
      rc[enq_ptr_i] = cnt;
      if (cnt == 0) pend[enq_ptr_i] = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    settle();
    finish_cycle();
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    rst = 1'b1;
    m_clear();
    settle();
    chk("rst_free_valid", free_valid_o, 1'b0);
    chk("rst_enq_ready", enq_ready_o, 1'b1);
    for (int p = 0; p < NP; p++) chk($sformatf("rst_voq_ptr[%0d]", p), voq_ptr_o[p], 0);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl [12];
  int   exp_order [4];
  int   start;
  int   pick;

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    #2;
    do_reset();

    //           ev    ptr   mask     rdy      rdy   vv       p1    fv    fp
    tbl[0]  = '{1'b1, 4'd5, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'd0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 4'd0, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'd5, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 4'd0, 4'b0000, 4'b0010, 1'b1, 4'b0010, 4'd5, 1'b0, 4'd0};
    tbl[3]  = '{1'b1, 4'd3, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'd0, 1'b1, 4'd5};
    tbl[4]  = '{1'b0, 4'd0, 4'b0000, 4'b0101, 1'b1, 4'b1111, 4'd3, 1'b0, 4'd0};
    tbl[5]  = '{1'b0, 4'd0, 4'b0000, 4'b0000, 1'b1, 4'b1010, 4'd3, 1'b0, 4'd0};
    tbl[6]  = '{1'b0, 4'd0, 4'b0000, 4'b1010, 1'b1, 4'b1010, 4'd3, 1'b0, 4'd0};
    tbl[7]  = '{1'b0, 4'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'd0, 1'b1, 4'd3};
    tbl[8]  = '{1'b0, 4'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'd0, 1'b0, 4'd0};
    tbl[9]  = '{1'b1, 4'd7, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'd0, 1'b0, 4'd0};
    tbl[10] = '{1'b0, 4'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'd0, 1'b1, 4'd7};
    tbl[11] = '{1'b0, 4'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'd0, 1'b0, 4'd0};

    foreach (tbl[i]) begin
      drive(tbl[i].ev, tbl[i].ptr, tbl[i].mask, tbl[i].rdy);
      settle();
      chk($sformatf("tbl%0d_enq_ready", i), enq_ready_o, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_voq_valid", i), voq_valid_o, tbl[i].exp_vv);
      chk($sformatf("tbl%0d_voq_ptr1", i), voq_ptr_o[1], tbl[i].exp_p1);
      chk($sformatf("tbl%0d_free_valid", i), free_valid_o, tbl[i].exp_fv);
      if (tbl[i].exp_fv) chk($sformatf("tbl%0d_free_ptr", i), free_ptr_o, tbl[i].exp_fp);
      finish_cycle();
    end

    // Full queue on port 0.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i), 4'b0001, 4'b0000);
      step();
    end
    drive(1'b0, 4'd0, 4'b0001, 4'b0000);
    settle(); chk("full_rdy_p0", enq_ready_o, 1'b0); finish_cycle();
    drive(1'b0, 4'd0, 4'b0100, 4'b0000);
    settle(); chk("full_rdy_p2", enq_ready_o, 1'b1); finish_cycle();
    drive(1'b0, 4'd0, 4'b0101, 4'b0000);
    settle(); chk("full_rdy_p0p2", enq_ready_o, 1'b0); finish_cycle();
    drive(1'b0, 4'd0, 4'b0001, 4'b0001);
    settle(); chk("full_rdy_pop_same", enq_ready_o, 1'b0); finish_cycle();
    drive(1'b0, 4'd0, 4'b0001, 4'b0000);
    settle(); chk("full_rdy_after_pop", enq_ready_o, 1'b1);
    chk("full_occ_after_pop", occupancy_o[0], 7); finish_cycle();
    drive(1'b0, 4'd0, 4'b0000, 4'b0001);
    for (int i = 0; i < 9; i++) step();
    drive(1'b0, 4'd0, 4'b0000, 4'b0000);
    for (int i = 0; i < 9; i++) step();

    // Push and pop on the same port at occupancy 4; FIFO order.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 4'b0100, 4'b0000);
      step();
    end
    drive(1'b1, 4'd9, 4'b0100, 4'b0100);
    settle(); chk("pp_occ_before", occupancy_o[2], 4); chk("pp_head1", voq_ptr_o[2], 1); finish_cycle();
    drive(1'b0, 4'd0, 4'b0000, 4'b0000);
    settle(); chk("pp_occ_after", occupancy_o[2], 4); finish_cycle();
    exp_order[0] = 2; exp_order[1] = 3; exp_order[2] = 4; exp_order[3] = 9;
    drive(1'b0, 4'd0, 4'b0000, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      settle(); chk($sformatf("pp_order%0d", i), voq_ptr_o[2], exp_order[i]); finish_cycle();
    end
    drive(1'b0, 4'd0, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) step();

    // Two slots reaching zero on the same edge.
    drive(1'b1, 4'd2, 4'b0001, 4'b0000); step();
    drive(1'b1, 4'd6, 4'b1000, 4'b0000); step();
    drive(1'b0, 4'd0, 4'b0000, 4'b1001); step();
    drive(1'b0, 4'd0, 4'b0000, 4'b0000);
    settle(); chk("dual_fv0", free_valid_o, 1'b1); chk("dual_fp0", free_ptr_o, 2); finish_cycle();
    settle(); chk("dual_fv1", free_valid_o, 1'b1); chk("dual_fp1", free_ptr_o, 6); finish_cycle();
    settle(); chk("dual_fv2", free_valid_o, 1'b0); finish_cycle();

    // Reset with frames queued.
    drive(1'b1, 4'd10, 4'b0001, 4'b0000); step();
    drive(1'b1, 4'd11, 4'b0110, 4'b0000); step();
    drive(1'b1, 4'd12, 4'b1000, 4'b0000); step();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("post_rst_free", free_valid_o, 1'b0);
      chk("post_rst_valid", voq_valid_o, 4'b0000);
`ifdef VOQ_STATS_EN
      chk("post_rst_hwm0", stat_hwm_o[0], 0);
`endif
      finish_cycle();
    end

    // Randomized traffic that respects the slot-reuse protocol.
    for (int n = 0; n < 3000; n++) begin
      logic [NP-1:0] mask;
      logic [NP-1:0] rdy;
      mask = NP'($urandom);
      rdy  = NP'($urandom);
      pick = -1;
      if (($urandom % 3) != 0 && m_ready(mask)) begin
        start = int'($urandom % VD);
        for (int k = 0; k < VD; k++) begin
          int s;
          s = (start + k) % VD;
          if (pick < 0 && rc[s] == 0 && !pend[s]) pick = s;
        end
      end
      if (pick >= 0) drive(1'b1, 4'(pick), mask, rdy);
      else drive(1'b0, 4'($urandom), mask, rdy);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
